// File: rtl/griffin_round_ctrl.sv
// Round sequencer for the griffinPi core: accepts one state, runs N_ROUNDS rounds, returns the result.
// Optional abort input is enabled by defining GRIFFIN_ROUND_CTRL_ABORT_EN.
module griffin_round_ctrl #(
  parameter int N_BITS     = 254,
  parameter int STATE_SIZE = 3,
  parameter int N_ROUNDS   = 14,
  parameter int RC_ADDR_W  = (N_ROUNDS > 2) ? $clog2(N_ROUNDS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     in_state,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     out_state,
  output logic [RC_ADDR_W-1:0]                  rc_addr,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     rc_data,
  output logic                                  pi_enable,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     pi_in_state,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     pi_round_constants,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     pi_out_state,
  input  logic                                  pi_done
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
  ,
  input  logic                                  abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
    ,
    S_DRAIN = 3'd5
`endif
  } state_t;

  state_t                            state;
  state_t                            state_nx;
  logic [RC_ADDR_W-1:0]              round;
  logic [STATE_SIZE-1:0][N_BITS-1:0] rc_q;
  logic                              last_round;
  logic                              abort_w;

`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_round = (round == RC_ADDR_W'(N_ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_FETCH;
      S_FETCH: state_nx = abort_w ? S_IDLE : S_ISSUE;
      S_ISSUE: state_nx = abort_w ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // An abort coinciding with pi_done has nothing left to drain.
        if (pi_done)      state_nx = abort_w ? S_IDLE : (last_round ? S_OUT : S_FETCH);
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
        else if (abort_w) state_nx = S_DRAIN;
`endif
      end
      S_OUT:   if (out_ready || abort_w) state_nx = S_IDLE;
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
      S_DRAIN: if (pi_done) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // ROM data arrives during ISSUE, so it is forwarded directly then and held from rc_q afterwards.
  always_comb begin
    in_ready           = (state == S_IDLE) && !reset;
    out_valid          = (state == S_OUT);
    pi_enable          = (state == S_ISSUE) && !abort_w;
    pi_round_constants = (state == S_ISSUE) ? rc_data : rc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round       <= '0;
      rc_addr     <= '0;
      pi_in_state <= '0;
      rc_q        <= '0;
      out_state   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            pi_in_state <= in_state;
            round       <= '0;
            rc_addr     <= '0;
          end
        end
        S_ISSUE: rc_q <= rc_data;
        S_WAIT: begin
          if (pi_done && !abort_w) begin
            pi_in_state <= pi_out_state;
            if (last_round) begin
              out_state <= pi_out_state;
            end else begin
              round   <= round + 1'b1;
              rc_addr <= round + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_griffin_round_ctrl.sv
// Testbench for griffin_round_ctrl: additive core model, synchronous RC ROM, directed and random jobs.
module tb_griffin_round_ctrl;
  localparam int NB = 254;
  localparam int SS = 3;
  localparam int NR = 14;
  localparam int AW = (NR > 2) ? $clog2(NR) : 1;
  localparam logic [NB:0] P = 255'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef logic [SS-1:0][NB-1:0] st_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic pi_done = 1'b0;
  logic spur = 1'b0;
  logic prev_en = 1'b0;
  logic in_ready, out_valid, pi_enable;
  logic [AW-1:0] rc_addr;
  st_t in_state = '0;
  st_t rc_data = '0;
  st_t pi_out_state = '0;
  st_t out_state, pi_in_state, pi_round_constants;
  st_t held_in, held_rc;
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int core_d = 4;
  int cnt = 0;
  int exp_round = 0;
  int en_job = 0;

  griffin_round_ctrl #(.N_BITS(NB), .STATE_SIZE(SS), .N_ROUNDS(NR)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .rc_addr(rc_addr), .rc_data(rc_data),
    .pi_enable(pi_enable), .pi_in_state(pi_in_state),
    .pi_round_constants(pi_round_constants),
    .pi_out_state(pi_out_state), .pi_done(pi_done)
`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  function automatic st_t rom_f(input int r);
    st_t v;
    for (int i = 0; i < SS; i++) v[i] = NB'(r + 1);
    return v;
  endfunction

  function automatic logic [NB-1:0] addp(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P) s = s - P;
    return s[NB-1:0];
  endfunction

  function automatic st_t mk3(input int a, input int b, input int c);
    st_t v;
    v[0] = NB'(a);
    v[1] = NB'(b);
    v[2] = NB'(c);
    return v;
  endfunction

  // Every round adds constant r+1, so the permutation adds 1+2+..+NR to each word.
  function automatic st_t expect_f(input st_t s);
    st_t e;
    for (int i = 0; i < SS; i++) e[i] = addp(s[i], NB'(NR * (NR + 1) / 2));
    return e;
  endfunction

  function automatic st_t rand_state();
    st_t v;
    logic [255:0] w;
    for (int i = 0; i < SS; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      v[i] = {4'b0, w[249:0]};
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [SS*NB-1:0] obs, input logic [SS*NB-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rc_data <= rom_f(int'(rc_addr));
  end

  // Core model: result = in + rc (mod p), pi_done core_d cycles after pi_enable.
  always @(negedge clk) begin
    pi_done = 1'b0;
    if (reset) begin
      cnt = 0;
      exp_round = 0;
      en_job = 0;
      prev_en = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_round = 0;
        en_job = 0;
      end
      if (pi_enable) begin
        chk("en_single", prev_en, 1'b0);
        chk("rc_addr_seq", rc_addr, exp_round);
        chk("rc_const", pi_round_constants, rom_f(exp_round));
        held_in = pi_in_state;
        held_rc = pi_round_constants;
        exp_round++;
        en_job++;
        cnt = core_d;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("pi_in_stable", pi_in_state, held_in);
          chk("pi_rc_stable", pi_round_constants, held_rc);
          for (int i = 0; i < SS; i++) pi_out_state[i] = addp(held_in[i], held_rc[i]);
          pi_done = 1'b1;
        end
      end
      if (spur) pi_done = 1'b1;
      prev_en = pi_enable;
    end
  end

  task automatic start(input st_t s, input bit keep, input st_t nxt, output int acc);
    int n = 0;
    @(posedge clk); #1;
    in_state = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 300, 1'b1);
    acc = cyc;
    @(posedge clk); #1;
    if (keep) in_state = nxt;
    else in_valid = 1'b0;
  endtask

  task automatic finish_job(input int acc, input st_t expv, input int lat, input int hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) chk("busy_in_ready", in_ready, 1'b0);
    end while (!out_valid && n < 3000);
    chk("out_timeout", out_valid, 1'b1);
    chk("latency", cyc - acc, lat);
    chk("out_state", out_state, expv);
    chk("en_count", en_job, NR);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_state", out_state, expv);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_drop", out_valid, 1'b0);
    chk("idle_ready", in_ready, 1'b1);
  endtask

  initial begin
    int acc;
    int n;
    st_t a, b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pi_enable", pi_enable, 1'b0);
    chk("rst_rc_addr", rc_addr, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_pi_in", pi_in_state, 0);
    chk("rst_pi_rc", pi_round_constants, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);

    // Spurious pi_done while idle
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_ready", in_ready, 1'b1);
    chk("spur_idle_en", pi_enable, 1'b0);
    chk("spur_idle_ov", out_valid, 1'b0);

    // Basic job with a spurious pi_done during FETCH
    start(mk3(0, 1, 2), 1'b0, '0, acc);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    finish_job(acc, expect_f(mk3(0, 1, 2)), NR * 6 + 1, 0);
    chk("basic_word2", out_state[2], NB'(2 + NR * (NR + 1) / 2));

    // Backpressure with in_valid held high into a second job
    a = rand_state();
    b = rand_state();
    start(a, 1'b1, b, acc);
    finish_job(acc, expect_f(a), NR * 6 + 1, 10);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_job(acc, expect_f(b), NR * 6 + 1, 0);

    // Reset in the middle of round 6
    start(mk3(9, 9, 9), 1'b0, '0, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pi_enable && rc_addr == AW'(6)) && n < 500);
    chk("round6_seen", n < 500, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_ov", out_valid, 1'b0);
    chk("post_rst_en", pi_enable, 1'b0);
    chk("post_rst_addr", rc_addr, 0);
    start(mk3(7, 7, 7), 1'b0, '0, acc);
    finish_job(acc, expect_f(mk3(7, 7, 7)), NR * 6 + 1, 2);

    // Random states, core latencies and output backpressure
    for (int j = 0; j < 4; j++) begin
      core_d = $urandom_range(1, 6);
      a = rand_state();
      start(a, 1'b0, '0, acc);
      finish_job(acc, expect_f(a), NR * (2 + core_d) + 1, $urandom_range(0, 3));
    end
    core_d = 4;

`ifdef GRIFFIN_ROUND_CTRL_ABORT_EN
    // Abort during WAIT of round 3
    a = rand_state();
    start(a, 1'b0, '0, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pi_enable && rc_addr == AW'(3)) && n < 500);
    chk("round3_seen", n < 500, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      chk("abort_no_out", out_valid, 1'b0);
    end while (!pi_done && n < 50);
    chk("drain_done_seen", pi_done, 1'b1);
    chk("drain_busy", in_ready, 1'b0);
    @(negedge clk);
    chk("abort_idle_ready", in_ready, 1'b1);
    chk("abort_idle_ov", out_valid, 1'b0);
    a = rand_state();
    start(a, 1'b0, '0, acc);
    finish_job(acc, expect_f(a), NR * 6 + 1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
